sel_mux_reg: RTL
================

SEL_MUX_REG -- requirements
Module: sel_mux_reg

Interface
REQ-001 Parameter W, default 8, data width per channel in bits.
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SW, default $clog2(N), select/channel-index width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 d  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
REQ-007 v  input  N  per-channel valid; bit k qualifies channel k.
REQ-008 s  input  SW  channel select used in fixed mode.
REQ-009 mode  input  1  0 = fixed select via s, 1 = round-robin among valid channels.
REQ-010 ack  output  N  one-hot combinational accept; ack[k]=1 means channel k's data is captured at this edge.
REQ-011 o  output  W  registered selected data.
REQ-012 o_valid  output  1  o/o_ch hold an unconsumed item.
REQ-013 o_ch  output  SW  index of the channel that produced o.
REQ-014 o_ready  input  1  downstream accept; item is consumed when o_valid && o_ready at an edge.

Function
REQ-015 Output stage SHALL be a single-entry register with two states: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-016 load_ok SHALL be 1 when EMPTY, or when FULL and o_ready=1 (same-cycle consume and refill).
REQ-017 Mode 0: grant channel s when s < N, v[s]=1 and load_ok; otherwise no grant.
REQ-018 Mode 0 with s >= N SHALL produce no grant and leave all state unchanged except normal consumption.
REQ-019 Mode 1: grant the first channel k with v[k]=1, searching ptr, ptr+1, ..., wrapping modulo N, when load_ok.
REQ-020 On a mode-1 grant to channel g, ptr SHALL become (g+1) mod N at the edge; with N=4 and g=3, ptr becomes 0.
REQ-021 ptr SHALL not change in mode 0 or on cycles without a mode-1 grant.
REQ-022 ack SHALL be all-zero or one-hot, and SHALL be asserted only for the granted channel in the grant cycle.
REQ-023 On a grant, at the edge: o <= d[g], o_ch <= g, o_valid <= 1. Latency from grant to o_valid is exactly 1 cycle.
REQ-024 When FULL, o_ready=1 and there is no grant: o_valid <= 0. o and o_ch SHALL hold their last values.
REQ-025 When FULL and o_ready=0: o, o_ch and o_valid SHALL hold; ack SHALL be all-zero (backpressure).
REQ-026 A change of mode or s SHALL take effect in the same cycle's grant logic; no state is flushed.
REQ-027 Sustained throughput SHALL be one item per cycle while o_ready=1 and a grantable channel exists.
REQ-028 Grant selection is purely combinational from v, s, mode, ptr and load_ok. No dependency on d.

Reset
REQ-029 While reset=1 at an edge: o_valid <= 0, o <= 0, o_ch <= 0, ptr <= 0.
REQ-030 While reset=1, ack SHALL be all-zero regardless of other inputs.
REQ-031 Asserting reset while FULL SHALL discard the held item; no ack is issued in that cycle.

Structure
REQ-032 A shared package SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the default W/N values.
REQ-033 One sub-module onehot_dec(SW,N) SHALL convert an index plus enable into an N-bit one-hot vector, all-zero when index >= N; it is used for ack generation.
REQ-034 The round-robin search SHALL be parametric in N (loop/generate), with no hard-coded channel count.

Verification
REQ-035 Reset: hold reset=1 for 2 cycles with v=4'b1111 -> ack=0, o_valid=0, o=0, o_ch=0 throughout.
REQ-036 Fixed mode: mode=0, s=2, v=4'b0100, d[2]=8'hA5, o_ready=1 -> ack=4'b0100 in that cycle; next cycle o=8'hA5, o_ch=2, o_valid=1.
REQ-037 Round-robin wrap: mode=1, v=4'b1111, o_ready=1 for 5 cycles from reset -> grants on channels 0,1,2,3,0 in order, one per cycle, with o_ch following one cycle later.
REQ-038 Round-robin skip: mode=1, ptr=1, v=4'b1001 -> grant channel 3, then ptr=0; next grant is channel 0.
REQ-039 Backpressure: FULL with o_ready=0 for 3 cycles and v=4'b1111 -> ack=0, o/o_ch/o_valid stable. Release o_ready=1 -> consume and refill in the same cycle.
REQ-040 Boundary: N=3, mode=0, s=3, v=3'b111 -> no ack. A reset pulse while FULL -> o_valid=0 on the next cycle.

Source files
------------

// File: rtl/sel_mux_reg_pkg.sv
// Shared constants and types for the selecting mux register.
// Mode encodings, default sizes and output-stage state.
package sel_mux_reg_pkg;
  localparam int DEF_W = 8;
  localparam int DEF_N = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_e;
endpackage

// File: rtl/sel_mux_reg_onehot_dec.sv
// Index-plus-enable to one-hot decoder.
// Indices at or beyond N decode to all-zero.
module onehot_dec #(
  parameter int SW = 2,
  parameter int N  = 4
) (
  input  logic [SW-1:0] idx_i,
  input  logic          en_i,
  output logic [N-1:0]  oh_o
);

  always_comb begin
    oh_o = '0;
    for (int k = 0; k < N; k++) begin
      if (en_i && idx_i == SW'(k)) begin
        oh_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_mux_reg.sv
// N-channel selector feeding a single-entry output register.
// Fixed select or round-robin among valid channels.
module sel_mux_reg
  import sel_mux_reg_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int N  = DEF_N,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] d,
  input  logic [N-1:0]   v,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   o,
  output logic           o_valid,
  output logic [SW-1:0]  o_ch,
  input  logic           o_ready
);

  ostate_e       state_q, state_d;
  logic [W-1:0]  o_q, o_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load_ok;
  logic          fx_hit, rr_hit, hit, grant;
  logic [SW-1:0] rr_idx, g_idx;
  logic [SW-1:0] cidx;
  int            c;

  assign load_ok = (state_q == ST_EMPTY) || o_ready;

  always_comb begin
    fx_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (s == SW'(k) && v[k]) begin
        fx_hit = 1'b1;
      end
    end
  end

  // Walk from the farthest offset back to ptr so the nearest wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    c      = 0;
    cidx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr_q) + i;
      if (c >= N) begin
        c = c - N;
      end
      cidx = SW'(c);
      if (v[cidx]) begin
        rr_hit = 1'b1;
        rr_idx = cidx;
      end
    end
  end

  assign hit   = (mode == MODE_RR) ? rr_hit : fx_hit;
  assign g_idx = (mode == MODE_RR) ? rr_idx : s;
  assign grant = !reset && load_ok && hit;

  onehot_dec #(
    .SW(SW),
    .N (N)
  ) u_dec (
    .idx_i(g_idx),
    .en_i (grant),
    .oh_o (ack)
  );

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (grant) begin
      state_d = ST_FULL;
      ch_d    = g_idx;
      for (int k = 0; k < N; k++) begin
        if (g_idx == SW'(k)) begin
          o_d = d[k*W +: W];
        end
      end
      if (mode == MODE_RR) begin
        if (int'(g_idx) == N - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = g_idx + 1'b1;
        end
      end
    end else if (state_q == ST_FULL && o_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      o_q     <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o       = o_q;
  assign o_ch    = ch_q;
  assign o_valid = (state_q == ST_FULL);

endmodule
